// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: bit-reversed sample input and natural-order output stream bundle.
interface fft_bitrev_reorder_if #(parameter int width = 12);
    logic signed [width-1:0] R_in, I_in, out_re, out_im;
    logic in_valid, in_start, in_ready, out_valid, out_last, out_ready, ovf;
    modport master (
        output R_in, I_in, in_valid, in_start, out_ready,
        input  in_ready, out_re, out_im, out_valid, out_last, ovf
    );
    modport slave (
        input  R_in, I_in, in_valid, in_start, out_ready,
        output in_ready, out_re, out_im, out_valid, out_last, ovf
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order.
module fft_bitrev_reorder #(
    parameter int width = 12,
    parameter int N = 8,
    localparam int log_n = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    fft_bitrev_reorder_if.slave bus
);
    localparam logic [log_n-1:0] last = log_n'(N - 1);
    function automatic logic [log_n-1:0] bitrev(input logic [log_n-1:0] a);
        logic [log_n-1:0] r;
        for (int i = 0; i < log_n; i++) r[i] = a[log_n-1-i];
        return r;
    endfunction
    logic [2*width-1:0] mem [2][N];
    logic [log_n-1:0] wr_cnt, rd_cnt, idx;
    logic [1:0] full;
    logic wb, rb, acc, load;
    assign bus.in_ready = !full[wb];
    assign acc = bus.in_valid && bus.in_ready;
    assign idx = bus.in_start ? '0 : wr_cnt;
    assign load = full[rb] && (!bus.out_valid || bus.out_ready);
    always_ff @(posedge clk)
        if (acc) mem[wb][bitrev(idx)] <= {bus.R_in, bus.I_in};
    // write and read banks never coincide while both are active, so full bits never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wb            <= 1'b0;
            rb            <= 1'b0;
            full          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_last  <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            if (acc) begin
                if (idx == last) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                    wr_cnt   <= '0;
                end else begin
                    wr_cnt <= idx + 1'b1;
                end
            end else if (bus.in_valid) begin
                bus.ovf <= 1'b1;
            end
            if (load) begin
                {bus.out_re, bus.out_im} <= mem[rb][rd_cnt];
                bus.out_last  <= rd_cnt == last;
                bus.out_valid <= 1'b1;
                if (rd_cnt == last) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                    rd_cnt   <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed scenarios with hand-computed natural-order expectations.
module tb_fft_bitrev_reorder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nerr = 0;
    int ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [11:0] q_re[$];
    logic [11:0] q_im[$];
    logic q_last[$];

    fft_bitrev_reorder_if #(.width(12)) bus();
    fft_bitrev_reorder #(.width(12), .N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // capture every output handshake, then advance to just after the next rising edge
    task automatic cyc();
        if (bus.out_valid && bus.out_ready) begin
            q_re.push_back(bus.out_re);
            q_im.push_back(bus.out_im);
            q_last.push_back(bus.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input bit v, input bit s);
        bus.R_in = 12'(r);
        bus.I_in = 12'(-r);
        bus.in_valid = v;
        bus.in_start = s;
    endtask

    task automatic do_reset();
        drive(0, 0, 0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_re.delete();
        q_im.delete();
        q_last.delete();
    endtask

    task automatic test_reset();
        drive(0, 0, 0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.ovf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_flags: got valid=%b last=%b ovf=%b, want 0 0 0", bus.out_valid, bus.out_last, bus.ovf);
        end
        nvec++;
        if (bus.out_re !== 12'd0 || bus.out_im !== 12'd0) begin
            nerr++;
            $display("FAIL reset_data: got re=%0d im=%0d, want 0 0", bus.out_re, bus.out_im);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ready: got in_ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ordering();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(k, 1, k == 0);
            cyc();
        end
        drive(0, 0, 0);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL order_latency_early: got valid=%b, want 0", bus.out_valid);
        end
        cyc();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== 12'd0) begin
            nerr++;
            $display("FAIL order_latency_first: got valid=%b re=%0d, want 1 0", bus.out_valid, bus.out_re);
        end
        repeat (10) cyc();
        nvec++;
        if (q_re.size() != 8) begin
            nerr++;
            $display("FAIL order_count: got %0d outputs, want 8", q_re.size());
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (q_re[i] !== 12'(ord[i]) || q_im[i] !== 12'(-ord[i]) || q_last[i] !== (i == 7)) begin
                nerr++;
                $display("FAIL order[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], ord[i], -ord[i], i == 7);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit lo = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 8; k++) begin
                drive(16 * f + k, 1, f == 0 && k == 0);
                if (!bus.in_ready) lo = 1;
                cyc();
            end
        drive(0, 0, 0);
        repeat (12) cyc();
        nvec++;
        if (lo || bus.ovf !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_flow: got in_ready_low=%b ovf=%b, want 0 0", lo, bus.ovf);
        end
        nvec++;
        if (q_re.size() != 32) begin
            nerr++;
            $display("FAIL b2b_count: got %0d outputs, want 32", q_re.size());
        end
        for (int i = 0; i < 32; i++) begin
            int e = 16 * (i / 8) + ord[i % 8];
            nvec++;
            if (q_re[i] !== 12'(e) || q_im[i] !== 12'(-e) || q_last[i] !== (i % 8 == 7)) begin
                nerr++;
                $display("FAIL b2b[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], e, -e, i % 8 == 7);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(k, 1, 0);
            if (k < 16) acc += int'(bus.in_ready);
            else begin
                nvec++;
                if (bus.in_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL bp_ready_17th: got in_ready=%b, want 0", bus.in_ready);
                end
            end
            cyc();
        end
        drive(0, 0, 0);
        nvec++;
        if (acc != 16 || bus.ovf !== 1'b1) begin
            nerr++;
            $display("FAIL bp_accept: got accepted=%0d ovf=%b, want 16 1", acc, bus.ovf);
        end
        repeat (3) cyc();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== 12'd0 || bus.out_im !== 12'd0) begin
            nerr++;
            $display("FAIL bp_hold: got valid=%b re=%0d im=%0d, want 1 0 0", bus.out_valid, bus.out_re, bus.out_im);
        end
        bus.out_ready = 1'b1;
        repeat (20) cyc();
        nvec++;
        if (q_re.size() != 16) begin
            nerr++;
            $display("FAIL bp_count: got %0d outputs, want 16", q_re.size());
        end
        for (int i = 0; i < 16; i++) begin
            int e = 8 * (i / 8) + ord[i % 8];
            nvec++;
            if (q_re[i] !== 12'(e) || q_im[i] !== 12'(-e) || q_last[i] !== (i % 8 == 7)) begin
                nerr++;
                $display("FAIL bp[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], e, -e, i % 8 == 7);
            end
        end
    endtask

    task automatic test_resync();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(100 + k, 1, k == 0);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            drive(32 + k, 1, k == 0);
            cyc();
        end
        drive(0, 0, 0);
        repeat (12) cyc();
        nvec++;
        if (q_re.size() != 8) begin
            nerr++;
            $display("FAIL resync_count: got %0d outputs, want 8", q_re.size());
        end
        for (int i = 0; i < 8; i++) begin
            int e = 32 + ord[i];
            nvec++;
            if (q_re[i] !== 12'(e) || q_im[i] !== 12'(-e) || q_last[i] !== (i == 7)) begin
                nerr++;
                $display("FAIL resync[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], e, -e, i == 7);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat = 4'b1001;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            logic pv;
            logic [11:0] pre, pim;
            if (c < 8) drive(48 + c, 1, c == 0);
            else drive(0, 0, 0);
            bus.out_ready = pat[c % 4];
            pv = bus.out_valid && !bus.out_ready;
            pre = bus.out_re;
            pim = bus.out_im;
            cyc();
            if (pv) begin
                nvec++;
                if (bus.out_valid !== 1'b1 || bus.out_re !== pre || bus.out_im !== pim) begin
                    nerr++;
                    $display("FAIL stall_hold[c=%0d]: got valid=%b re=%0d im=%0d, want 1 %0d %0d",
                             c, bus.out_valid, $signed(bus.out_re), $signed(bus.out_im), $signed(pre), $signed(pim));
                end
            end
        end
        nvec++;
        if (q_re.size() != 8) begin
            nerr++;
            $display("FAIL stall_count: got %0d outputs, want 8", q_re.size());
        end
        for (int i = 0; i < 8; i++) begin
            int e = 48 + ord[i];
            nvec++;
            if (q_re[i] !== 12'(e) || q_im[i] !== 12'(-e) || q_last[i] !== (i == 7)) begin
                nerr++;
                $display("FAIL stall[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], e, -e, i == 7);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(64 + k, 1, k == 0);
            cyc();
        end
        drive(0, 0, 0);
        for (int c = 0; c < 20 && !found; c++)
            if (bus.out_valid && bus.out_re == 12'd70) found = 1;
            else cyc();
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL rstmid_bin3_timeout: got no bin 3 within 20 cycles, want re=70");
        end
        #1;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_re !== 12'd0) begin
            nerr++;
            $display("FAIL rstmid_async: got valid=%b ovf=%b in_ready=%b re=%0d, want 0 0 1 0",
                     bus.out_valid, bus.ovf, bus.in_ready, bus.out_re);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_re.delete();
        q_im.delete();
        q_last.delete();
        for (int k = 0; k < 8; k++) begin
            drive(80 + k, 1, 0);
            cyc();
        end
        drive(0, 0, 0);
        repeat (12) cyc();
        nvec++;
        if (q_re.size() != 8) begin
            nerr++;
            $display("FAIL rstmid_count: got %0d outputs, want 8", q_re.size());
        end
        for (int i = 0; i < 8; i++) begin
            int e = 80 + ord[i];
            nvec++;
            if (q_re[i] !== 12'(e) || q_im[i] !== 12'(-e) || q_last[i] !== (i == 7)) begin
                nerr++;
                $display("FAIL rstmid[%0d]: got re=%0d im=%0d last=%b, want re=%0d im=%0d last=%b",
                         i, $signed(q_re[i]), $signed(q_im[i]), q_last[i], e, -e, i == 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
